// File: rtl/sha_block_ctrl.sv
// SHA-256 message-block controller: packs 64-bit words into 512-bit blocks,
// appends 0x80 / zero fill / 64-bit bit length, and hands blocks to the core.
module sha_block_ctrl #(
    parameter int LEN_W = 64
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [63:0]  i_in_data,
    input  logic         i_in_last,
    input  logic [3:0]   i_in_bytes,
    output logic         o_blk_valid,
    input  logic         i_blk_ready,
    output logic [511:0] o_blk_data,
    output logic         o_blk_first,
    output logic         o_blk_last,
    output logic         o_msg_busy
);

    localparam logic [63:0] MARK_WORD = 64'h8000_0000_0000_0000;

    typedef enum logic [1:0] {
        S_FILL,
        S_PAD,
        S_SEND,
        S_LENBLK
    } state_t;

    state_t             r_state;
    logic [2:0]         r_wi;
    logic [2:0]         r_k;
    logic [LEN_W-1:0]   r_len;
    logic [63:0]        r_w [8];
    logic               r_in_ready;
    logic               r_blk_valid;
    logic               r_blk_first;
    logic               r_blk_last;
    logic               r_busy;
    logic               r_first_pend;
    logic               r_more;
    logic               r_mark0;

    logic               w_accept;
    logic [3:0]         w_n;
    logic               w_full;
    logic [5:0]         w_nbits;
    logic [63:0]        w_keep;
    logic [63:0]        w_mark;
    logic [63:0]        w_padword;
    logic [6:0]         w_len_add;
    logic [LEN_W-1:0]   w_len_nxt;
    logic [63:0]        w_len_ext;
    logic [2:0]         w_wi1;

    // in_ready is forced low combinationally while reset is held so that it
    // can read 1 on the very first cycle after release.
    assign o_in_ready  = r_in_ready & ~i_rst;
    assign o_blk_valid = r_blk_valid;
    assign o_blk_first = r_blk_first;
    assign o_blk_last  = r_blk_last;
    assign o_msg_busy  = r_busy;

    assign w_accept  = i_in_valid && o_in_ready;
    assign w_n       = (i_in_bytes == 4'd0 || i_in_bytes > 4'd8) ? 4'd8 : i_in_bytes;
    assign w_full    = w_n[3];
    assign w_nbits   = {w_n[2:0], 3'b000};
    assign w_keep    = ~(64'hFFFF_FFFF_FFFF_FFFF >> w_nbits);
    assign w_mark    = MARK_WORD >> w_nbits;
    assign w_padword = (i_in_data & w_keep) | w_mark;
    assign w_len_add = i_in_last ? {w_n, 3'b000} : 7'd64;
    assign w_len_nxt = r_len + LEN_W'(w_len_add);
    assign w_wi1     = r_wi + 3'd1;

    always_comb begin
        w_len_ext = '0;
        w_len_ext[LEN_W-1:0] = r_len;
    end

    always_comb begin
        o_blk_data = '0;
        for (int i = 0; i < 8; i++)
            o_blk_data[511-64*i -: 64] = r_w[i];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_FILL;
            r_wi         <= '0;
            r_k          <= '0;
            r_len        <= '0;
            r_in_ready   <= 1'b1;
            r_blk_valid  <= 1'b0;
            r_blk_first  <= 1'b0;
            r_blk_last   <= 1'b0;
            r_busy       <= 1'b0;
            r_first_pend <= 1'b1;
            r_more       <= 1'b0;
            r_mark0      <= 1'b0;
            for (int i = 0; i < 8; i++)
                r_w[i] <= '0;
        end else begin
            case (r_state)
                S_FILL: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_busy <= 1'b1;
                        r_len  <= w_len_nxt;
                        if (!i_in_last) begin
                            r_w[r_wi] <= i_in_data;
                            r_wi      <= w_wi1;
                            if (r_wi == 3'd7) begin
                                r_state     <= S_SEND;
                                r_in_ready  <= 1'b0;
                                r_blk_valid <= 1'b1;
                                r_blk_first <= r_first_pend;
                                r_blk_last  <= 1'b0;
                                r_more      <= 1'b0;
                            end
                        end else if (!w_full) begin
                            r_w[r_wi]  <= w_padword;
                            r_k        <= r_wi;
                            r_state    <= S_PAD;
                            r_in_ready <= 1'b0;
                        end else if (r_wi != 3'd7) begin
                            r_w[r_wi]  <= i_in_data;
                            r_w[w_wi1] <= MARK_WORD;
                            r_k        <= w_wi1;
                            r_state    <= S_PAD;
                            r_in_ready <= 1'b0;
                        end else begin
                            // Full last word fills the block: marker and length go in an extra block.
                            r_w[7]      <= i_in_data;
                            r_state     <= S_SEND;
                            r_in_ready  <= 1'b0;
                            r_blk_valid <= 1'b1;
                            r_blk_first <= r_first_pend;
                            r_blk_last  <= 1'b0;
                            r_more      <= 1'b1;
                            r_mark0     <= 1'b1;
                        end
                    end
                end

                S_PAD: begin
                    for (int i = 0; i < 7; i++)
                        if (i > int'(r_k))
                            r_w[i] <= '0;
                    r_state     <= S_SEND;
                    r_blk_valid <= 1'b1;
                    r_blk_first <= r_first_pend;
                    if (r_k != 3'd7) begin
                        r_w[7]     <= w_len_ext;
                        r_blk_last <= 1'b1;
                        r_more     <= 1'b0;
                    end else begin
                        r_blk_last <= 1'b0;
                        r_more     <= 1'b1;
                        r_mark0    <= 1'b0;
                    end
                end

                S_LENBLK: begin
                    r_w[0] <= r_mark0 ? MARK_WORD : 64'd0;
                    for (int i = 1; i < 7; i++)
                        r_w[i] <= '0;
                    r_w[7]      <= w_len_ext;
                    r_state     <= S_SEND;
                    r_blk_valid <= 1'b1;
                    r_blk_first <= r_first_pend;
                    r_blk_last  <= 1'b1;
                    r_more      <= 1'b0;
                end

                default: begin
                    if (i_blk_ready) begin
                        r_blk_valid  <= 1'b0;
                        r_blk_first  <= 1'b0;
                        r_blk_last   <= 1'b0;
                        r_first_pend <= 1'b0;
                        if (r_more) begin
                            r_state <= S_LENBLK;
                        end else begin
                            r_state    <= S_FILL;
                            r_wi       <= '0;
                            r_in_ready <= 1'b1;
                            if (r_blk_last) begin
                                r_len        <= '0;
                                r_busy       <= 1'b0;
                                r_first_pend <= 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha_block_ctrl.sv
// Scoreboard bench for sha_block_ctrl: a byte-level SHA-256 padding model
// predicts every block; a negedge monitor compares each transferred block.
module tb_sha_block_ctrl;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_in_valid = 1'b0;
    logic         o_in_ready;
    logic [63:0]  i_in_data = '0;
    logic         i_in_last = 1'b0;
    logic [3:0]   i_in_bytes = 4'd8;
    logic         o_blk_valid;
    logic         i_blk_ready = 1'b1;
    logic [511:0] o_blk_data;
    logic         o_blk_first;
    logic         o_blk_last;
    logic         o_msg_busy;

    sha_block_ctrl #(.LEN_W(64)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .i_in_data(i_in_data), .i_in_last(i_in_last), .i_in_bytes(i_in_bytes),
        .o_blk_valid(o_blk_valid), .i_blk_ready(i_blk_ready),
        .o_blk_data(o_blk_data), .o_blk_first(o_blk_first),
        .o_blk_last(o_blk_last), .o_msg_busy(o_msg_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [511:0] data;
        logic         first;
        logic         last;
    } blk_t;

    blk_t         sb_q[$];
    int           rise_q[$];
    int           xfer_q[$];
    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    int           rdy_mode = 1;
    logic [511:0] last_data = '0;

    bit           m_hold = 0, m_xf = 0, m_fin = 0;
    logic [511:0] m_pd;
    logic         m_pf, m_pl;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i >= 0 && i < q.size()) ? q[i] : -1000;
    endfunction

    // Reference: message bytes || 0x80 || zeros to 56 mod 64 || 64-bit bit length.
    function automatic void push_expected(input logic [63:0] words[$], input logic [3:0] inb);
        logic [7:0]  p[$];
        logic [63:0] bits;
        int          n, cnt, nb;
        blk_t        e;
        n = (inb == 4'd0 || inb > 4'd8) ? 8 : int'(inb);
        foreach (words[i]) begin
            cnt = (i == words.size() - 1) ? n : 8;
            for (int b = 0; b < cnt; b++) p.push_back(words[i][63-8*b -: 8]);
        end
        bits = 64'(p.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        nb = p.size() / 64;
        for (int b = 0; b < nb; b++) begin
            e.data = '0;
            for (int j = 0; j < 64; j++) e.data[511-8*j -: 8] = p[64*b + j];
            e.first = (b == 0);
            e.last  = (b == nb - 1);
            sb_q.push_back(e);
        end
    endfunction

    task automatic send_word(input logic [63:0] d, input logic last, input logic [3:0] nb, output int acc);
        i_in_valid = 1'b1;
        i_in_data  = d;
        i_in_last  = last;
        i_in_bytes = nb;
        acc = -1;
        for (int k = 0; k < 400 && acc < 0; k++) begin
            @(negedge i_clk);
            if (o_in_ready) acc = cyc;
            @(posedge i_clk);
            #1;
        end
        if (acc < 0) chk1("in_ready_timeout", 1'b0, 1'b1);
        i_in_valid = 1'b0;
        i_in_data  = {$urandom, $urandom};
        i_in_last  = 1'b0;
    endtask

    task automatic send_msg(input logic [63:0] words[$], input logic [3:0] inb, input int gap, output int acc_last);
        int acc;
        acc_last = -1;
        push_expected(words, inb);
        foreach (words[i]) begin
            if (gap > 0) repeat ($urandom_range(0, gap)) begin @(posedge i_clk); #1; end
            send_word(words[i], i == words.size() - 1, inb, acc);
            if (i == 0) chk1("busy_after_first", o_msg_busy, 1'b1);
            acc_last = acc;
        end
    endtask

    task automatic wait_drain(input int budget);
        int k;
        for (k = 0; k < budget && (sb_q.size() > 0 || o_blk_valid); k++) begin
            @(posedge i_clk);
            #1;
        end
        if (sb_q.size() > 0 || o_blk_valid) chk1("drain_timeout", 1'b0, 1'b1);
    endtask

    initial forever begin
        @(posedge i_clk);
        cyc++;
    end

    initial forever begin
        @(posedge i_clk);
        #2;
        case (rdy_mode)
            0: i_blk_ready = 1'($urandom_range(0, 1));
            1: i_blk_ready = 1'b1;
            2: i_blk_ready = 1'b0;
            default: ;
        endcase
    end

    // Monitor: pops the scoreboard on every transfer and checks handshake rules.
    initial forever begin
        blk_t e;
        @(negedge i_clk);
        if (i_rst) begin
            m_hold = 0; m_xf = 0; m_fin = 0;
        end else begin
            if (m_fin) begin
                chk1("idle_busy", o_msg_busy, 1'b0);
                chk1("idle_in_ready", o_in_ready, 1'b1);
            end
            if (m_xf) chk1("no_back_to_back", o_blk_valid, 1'b0);
            if (m_hold) begin
                chk1("hold_valid", o_blk_valid, 1'b1);
                chk("hold_data", o_blk_data, m_pd);
                chk1("hold_first", o_blk_first, m_pf);
                chk1("hold_last", o_blk_last, m_pl);
            end
            if (o_blk_valid) begin
                if (!m_hold) rise_q.push_back(cyc);
                chk1("in_ready_during_send", o_in_ready, 1'b0);
            end
            m_xf   = o_blk_valid && i_blk_ready;
            m_fin  = m_xf && o_blk_last;
            m_hold = o_blk_valid && !i_blk_ready;
            m_pd = o_blk_data; m_pf = o_blk_first; m_pl = o_blk_last;
            if (m_xf) begin
                xfer_q.push_back(cyc);
                last_data = o_blk_data;
                if (sb_q.size() == 0) begin
                    chk1("unexpected_block", 1'b1, 1'b0);
                end else begin
                    e = sb_q.pop_front();
                    chk("blk_data", o_blk_data, e.data);
                    chk1("blk_first", o_blk_first, e.first);
                    chk1("blk_last", o_blk_last, e.last);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, rc, nw;
        logic [3:0] inb;
        logic [63:0] wq[$];

        repeat (3) @(posedge i_clk);
        #1;
        chk1("rst_in_ready", o_in_ready, 1'b0);
        chk1("rst_valid", o_blk_valid, 1'b0);
        chk1("rst_first", o_blk_first, 1'b0);
        chk1("rst_last", o_blk_last, 1'b0);
        chk1("rst_busy", o_msg_busy, 1'b0);
        chk("rst_data", o_blk_data, 512'd0);
        i_rst = 1'b0;
        #1;
        chk1("release_in_ready", o_in_ready, 1'b1);

        // "abc"
        rise_q.delete(); xfer_q.delete();
        wq = {64'h6162_6300_0000_0000};
        send_msg(wq, 4'd3, 0, acc);
        wait_drain(50);
        chki("abc_latency", qat(rise_q, 0) - acc, 2);
        chk("abc_block", last_data, {64'h6162_6380_0000_0000, 384'd0, 64'h18});

        // 56 bytes: marker fills word 7, length needs an extra block
        rise_q.delete(); xfer_q.delete();
        wq = {};
        repeat (7) wq.push_back(64'h1111_1111_1111_1111);
        send_msg(wq, 4'd8, 0, acc);
        wait_drain(50);
        chki("lenblk_gap", qat(rise_q, 1) - qat(xfer_q, 0), 2);
        chk("b56_lenblk", last_data, {448'd0, 64'h1C0});

        // 64 bytes: full data block then marker+length block
        rise_q.delete(); xfer_q.delete();
        wq = {};
        repeat (8) wq.push_back({$urandom, $urandom});
        send_msg(wq, 4'd8, 0, acc);
        wait_drain(50);
        chki("full_blk_latency", qat(rise_q, 0) - acc, 1);
        chk("b64_lenblk", last_data, {64'h8000_0000_0000_0000, 384'd0, 64'h200});

        // backpressure
        rdy_mode = 3;
        i_blk_ready = 1'b0;
        xfer_q.delete();
        wq = {64'h6162_6300_0000_0000};
        send_msg(wq, 4'd3, 0, acc);
        for (int k = 0; k < 20 && !o_blk_valid; k++) begin @(posedge i_clk); #1; end
        repeat (5) begin @(posedge i_clk); #1; end
        chk1("bp_valid_held", o_blk_valid, 1'b1);
        chk1("bp_in_ready", o_in_ready, 1'b0);
        i_blk_ready = 1'b1;
        rc = cyc;
        @(posedge i_clk);
        #1;
        chki("bp_xfer_cycle", qat(xfer_q, 0), rc);
        rdy_mode = 1;
        wait_drain(50);

        // back-to-back "abc" then "de"
        wq = {64'h6162_6300_0000_0000};
        send_msg(wq, 4'd3, 0, acc);
        wq = {64'h6465_DEAD_BEEF_0123};
        send_msg(wq, 4'd2, 0, acc);
        wait_drain(50);
        chk("de_block", last_data, {64'h6465_8000_0000_0000, 384'd0, 64'h10});

        // reset after 3 words of a 10-word message
        for (int i = 0; i < 3; i++) send_word({$urandom, $urandom}, 1'b0, 4'd8, acc);
        i_rst = 1'b1;
        #1;
        chk1("midrst_in_ready", o_in_ready, 1'b0);
        @(posedge i_clk);
        #1;
        chk1("midrst_busy", o_msg_busy, 1'b0);
        chk1("midrst_valid", o_blk_valid, 1'b0);
        chk("midrst_data", o_blk_data, 512'd0);
        i_rst = 1'b0;
        #1;
        chk1("midrst_rel_ready", o_in_ready, 1'b1);
        chk1("midrst_rel_busy", o_msg_busy, 1'b0);
        wq = {64'h6162_6300_0000_0000};
        send_msg(wq, 4'd3, 0, acc);
        wait_drain(50);
        chk("abc_after_rst", last_data, {64'h6162_6380_0000_0000, 384'd0, 64'h18});

        // randomized messages with gaps, random backpressure and illegal byte counts
        rdy_mode = 0;
        for (int m = 0; m < 40; m++) begin
            nw = $urandom_range(1, 12);
            wq = {};
            for (int i = 0; i < nw; i++) wq.push_back({$urandom, $urandom});
            inb = 4'($urandom_range(1, 8));
            if (inb == 4'd8 && $urandom_range(0, 3) == 0) inb = 4'($urandom_range(0, 1) == 0 ? 0 : $urandom_range(9, 15));
            send_msg(wq, inb, 2, acc);
        end
        wait_drain(400);
        chki("sb_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
